alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//   Shares one WIDTH-bit ALU (pass-A, pass-B, add, subtract, zero flag) between two requesters.
//   Round-robin arbitration, valid/ready request handshake, single registered response channel.
//   One transaction in flight at a time. Sits between client FSMs and the ALU datapath.
// PARAMETERS
//   WIDTH     10   operand/result width in bits
//   CNT_W     16   width of completed-operation counter
// PORTS
//   clk          in   1        rising-edge clock
//   rst_n        in   1        synchronous, active-low reset
//   req0_valid   in   1        requester 0 has an operation
//   req0_ready   out  1        requester 0 operation accepted this cycle
//   req0_a       in   WIDTH    requester 0 operand a
//   req0_b       in   WIDTH    requester 0 operand b
//   req0_mode    in   2        requester 0 mode: 0=a, 1=b, 2=a+b, 3=a-b
//   req1_valid   in   1        requester 1 has an operation
//   req1_ready   out  1        requester 1 operation accepted this cycle
//   req1_a       in   WIDTH    requester 1 operand a
//   req1_b       in   WIDTH    requester 1 operand b
//   req1_mode    in   2        requester 1 mode
//   rsp_valid    out  1        response available
//   rsp_ready    in   1        consumer takes response
//   rsp_id       out  1        requester that issued the response
//   rsp_y        out  WIDTH    ALU result
//   rsp_is_zero  out  1        1 when rsp_y == 0
//   busy         out  1        1 in any state other than IDLE
//   ops_done     out  CNT_W    count of responses consumed
// BEHAVIOUR
//   - Reset (rst_n=0 at clk edge): state=IDLE, rsp_valid=0, rsp_id=0, rsp_y=0, rsp_is_zero=0,
//     ops_done=0, last-grant pointer=1 (requester 0 wins first tie). Readies are 0 while rst_n=0.
//   - FSM: IDLE -> EXEC -> RESP -> IDLE.
//     IDLE: if any reqN_valid, grant one; reqN_ready=1 combinationally for the winner only
//       (never both); latch a, b, mode, id at the edge; go EXEC. No valid: stay IDLE.
//     EXEC: compute and register rsp_y, rsp_is_zero, rsp_id; set rsp_valid=1; go RESP.
//     RESP: hold all rsp_* stable while rsp_ready=0. On rsp_valid&rsp_ready: rsp_valid=0,
//       ops_done+1 (wraps at 2^CNT_W), go IDLE.
//   - Readies are 0 outside IDLE; requester inputs are ignored outside IDLE.
//   - Arbitration: only one valid -> grant it. Both valid -> grant the requester not granted
//     last; pointer updates only on an accepted grant.
//   - Latency: accept at edge N -> rsp_valid=1 after edge N+1. Min spacing between accepts is
//     3 cycles (rsp_ready held high).
//   - Arithmetic mod 2^WIDTH: mode2 = (a+b) truncated, mode3 = (a-b) two's-complement truncated;
//     carry/borrow discarded. is_zero from truncated result in every mode.
//   - Operands latched at accept; later changes on reqN_* do not affect the in-flight result.
//   - Reset mid-operation (EXEC or RESP): transaction dropped, no response, outputs to reset values.
//   - busy = (state != IDLE), combinational from state.
// TESTING
//   1. Reset: rst_n=0 two cycles, all valids=1 -> readies=0, rsp_valid=0, ops_done=0, busy=0.
//   2. Single req0 a=5,b=3,mode=2, rsp_ready=1 -> req0_ready in accept cycle; two edges later
//      rsp_valid=1, rsp_y=8, rsp_id=0, is_zero=0; ops_done=1.
//   3. Wrap: req1 a=1023,b=1,mode=2 -> rsp_y=0, is_zero=1; a=0,b=1,mode=3 -> rsp_y=1023, is_zero=0.
//   4. Both valid continuously, 4 ops, rsp_ready=1 -> grant order 0,1,0,1; rsp_id matches;
//      rsp_y correct per requester operands.
//   5. Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, readies=0, busy=1;
//      rsp_ready=1 -> IDLE next cycle, ops_done increments once.
//   6. Reset asserted in RESP, then released -> no response, ops_done unchanged at 0,
//      next req0 a=7,b=7,mode=3 -> rsp_y=0, is_zero=1.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// Request/response bus between two ALU clients, the shared arbiter and the response consumer.
interface alu_share_arbiter_if #(
    parameter int unsigned WIDTH = 10
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [1:0]       req0_mode;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [1:0]       req1_mode;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_y;
    logic             rsp_is_zero;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_mode,
        input  req1_valid, req1_a, req1_b, req1_mode,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_y, rsp_is_zero
    );

    // Client/consumer side
    modport master (
        output req0_valid, req0_a, req0_b, req0_mode,
        output req1_valid, req1_a, req1_b, req1_mode,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_y, rsp_is_zero
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one small ALU between two requesters, one transaction in flight.
module alu_share_arbiter #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_share_arbiter_if.slave    bus,
    output logic                  busy,
    output logic [CNT_W-1:0]      ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic             grant0_c;
    logic             grant1_c;
    logic             accept_c;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       mode_q;
    logic             id_q;
    logic             last_q;

    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_y_q;
    logic             rsp_is_zero_q;

    logic [WIDTH-1:0] alu_y_c;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and grant; requester 0 wins a tie when requester 1 was granted last
    always_comb begin
        state_nxt = state;
        grant0_c  = 1'b0;
        grant1_c  = 1'b0;
        unique case (state)
            IDLE: begin
                if (rst_n) begin
                    grant0_c = bus.req0_valid && (!bus.req1_valid || last_q);
                    grant1_c = bus.req1_valid && (!bus.req0_valid || !last_q);
                end
                if (grant0_c || grant1_c) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign accept_c = grant0_c || grant1_c;

    // ALU on the latched operands; carry and borrow are dropped by truncation
    always_comb begin
        alu_y_c = a_q;
        unique case (mode_q)
            2'd0:    alu_y_c = a_q;
            2'd1:    alu_y_c = b_q;
            2'd2:    alu_y_c = WIDTH'(a_q + b_q);
            default: alu_y_c = WIDTH'(a_q - b_q);
        endcase
    end

    // Operand capture, response register and completion counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q           <= '0;
            b_q           <= '0;
            mode_q        <= 2'd0;
            id_q          <= 1'b0;
            last_q        <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_y_q       <= '0;
            rsp_is_zero_q <= 1'b0;
            ops_done      <= '0;
        end else begin
            if (accept_c) begin
                a_q    <= grant1_c ? bus.req1_a    : bus.req0_a;
                b_q    <= grant1_c ? bus.req1_b    : bus.req0_b;
                mode_q <= grant1_c ? bus.req1_mode : bus.req0_mode;
                id_q   <= grant1_c;
                last_q <= grant1_c;
            end
            if (state == EXEC) begin
                rsp_y_q       <= alu_y_c;
                rsp_is_zero_q <= (alu_y_c == '0);
                rsp_id_q      <= id_q;
                rsp_valid_q   <= 1'b1;
            end
            if ((state == RESP) && rsp_valid_q && bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
                ops_done    <= ops_done + CNT_W'(1);
            end
        end
    end

    assign bus.req0_ready  = grant0_c;
    assign bus.req1_ready  = grant1_c;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_y       = rsp_y_q;
    assign bus.rsp_is_zero = rsp_is_zero_q;
    assign busy            = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized and directed bench for alu_share_arbiter with a queue-based scoreboard.
module tb_alu_share_arbiter;

    localparam int unsigned WIDTH = 10;
    localparam int unsigned CNT_W = 16;
    localparam int MOD = 1 << WIDTH;
    localparam int CMOD = 1 << CNT_W;

    typedef struct {
        int id;
        int y;
        int z;
    } exp_t;

    logic clk;
    logic rst_n;
    logic busy;
    logic [CNT_W-1:0] ops_done;

    alu_share_arbiter_if #(.WIDTH(WIDTH)) bus();

    alu_share_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .ops_done (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];

    // Reference state: one outstanding transaction, round-robin pointer, completion count
    bit m_known = 0;
    bit m_rst_prev = 0;
    bit m_out = 0;
    int m_age = 0;
    int m_last = 1;
    int m_ops = 0;

    function automatic int ref_y(input int a, input int b, input int m);
        case (m)
            0: return a;
            1: return b;
            2: return (a + b) % MOD;
            default: return (a - b + MOD) % MOD;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check combinational/state outputs, advance the model
    task automatic cycle(input bit v0, input int a0, input int b0, input int md0,
                         input bit v1, input int a1, input int b1, input int md1,
                         input bit rr, input bit rn);
        bit g0;
        bit g1;
        exp_t e;
        bus.req0_valid = v0;
        bus.req0_a     = WIDTH'(a0);
        bus.req0_b     = WIDTH'(b0);
        bus.req0_mode  = 2'(md0);
        bus.req1_valid = v1;
        bus.req1_a     = WIDTH'(a1);
        bus.req1_b     = WIDTH'(b1);
        bus.req1_mode  = 2'(md1);
        bus.rsp_ready  = rr;
        rst_n          = rn;
        g0 = rn && !m_out && v0 && (!v1 || m_last == 1);
        g1 = rn && !m_out && v1 && (!v0 || m_last == 0);
        @(negedge clk);
        chk("req0_ready", int'(bus.req0_ready), int'(g0));
        chk("req1_ready", int'(bus.req1_ready), int'(g1));
        if (m_known) begin
            chk("busy", int'(busy), int'(m_out));
            chk("ops_done", int'(ops_done), m_ops);
            chk("rsp_valid", int'(bus.rsp_valid), int'(m_out && m_age >= 1));
            if (m_rst_prev) begin
                chk("rst_rsp_y", int'(bus.rsp_y), 0);
                chk("rst_rsp_id", int'(bus.rsp_id), 0);
                chk("rst_rsp_is_zero", int'(bus.rsp_is_zero), 0);
            end
        end
        @(posedge clk);
        #1;
        if (!rn) begin
            m_out = 0;
            m_age = 0;
            m_last = 1;
            m_ops = 0;
            sb.delete();
            m_known = 1;
            m_rst_prev = 1;
        end else begin
            m_rst_prev = 0;
            if (g0 || g1) begin
                e.id = g1 ? 1 : 0;
                e.y  = g1 ? ref_y(a1 % MOD, b1 % MOD, md1) : ref_y(a0 % MOD, b0 % MOD, md0);
                e.z  = (e.y == 0) ? 1 : 0;
                sb.push_back(e);
                m_out = 1;
                m_age = 0;
                m_last = g1 ? 1 : 0;
            end else if (m_out) begin
                if (m_age == 0) begin
                    m_age = 1;
                end else if (rr) begin
                    m_out = 0;
                    m_ops = (m_ops + 1) % CMOD;
                end
            end
        end
    endtask

    task automatic idle(input int n, input bit rr);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, rr, 1);
    endtask

    // Scoreboard monitor: every presented response must match the oldest expectation
    always @(negedge clk) begin
        if (m_known && bus.rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_y=%0d with nothing expected at %0t",
                         bus.rsp_y, $time);
            end else begin
                chk("rsp_id", int'(bus.rsp_id), sb[0].id);
                chk("rsp_y", int'(bus.rsp_y), sb[0].y);
                chk("rsp_is_zero", int'(bus.rsp_is_zero), sb[0].z);
                if (bus.rsp_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_mode = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_mode = '0;
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset with both requesters valid
        cycle(1, 1, 2, 2, 1, 3, 4, 2, 1, 0);
        cycle(1, 1, 2, 2, 1, 3, 4, 2, 1, 0);

        // Single add on requester 0
        cycle(1, 5, 3, 2, 0, 0, 0, 0, 1, 1);
        idle(3, 1);

        // Wrap-around add and subtract on requester 1
        cycle(0, 0, 0, 0, 1, 1023, 1, 2, 1, 1);
        idle(3, 1);
        cycle(0, 0, 0, 0, 1, 0, 1, 3, 1, 1);
        idle(3, 1);

        // Both valid continuously: grants alternate
        for (int i = 0; i < 12; i++)
            cycle(1, 10 * i + 1, i, i % 4, 1, 200 + i, 7 * i, (i + 2) % 4, 1, 1);
        idle(3, 1);

        // Backpressure in RESP with both requesters still asserting
        cycle(1, 100, 50, 3, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) cycle(1, 9, 9, 2, 1, 8, 8, 2, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(3, 1);

        // Reset while the response is pending
        cycle(1, 9, 2, 3, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 7, 7, 3, 0, 0, 0, 0, 1, 1);
        idle(3, 1);

        // Randomized traffic with occasional backpressure and reset
        for (int i = 0; i < 400; i++) begin
            int a0, a1;
            a0 = ($urandom_range(0, 7) == 0) ? 1023 : int'($urandom_range(0, 1023));
            a1 = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 1023));
            cycle($urandom_range(0, 9) < 6, a0, $urandom_range(0, 1023), $urandom_range(0, 3),
                  $urandom_range(0, 9) < 6, a1, $urandom_range(0, 1023), $urandom_range(0, 3),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 59) != 0);
        end
        idle(4, 1);

        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
